// File: rtl/uart_echo_core.sv
// uart_echo_core: UART echo engine with baud tick, 16x RX, RX FIFO and TX; define UART_PARITY_EN for even parity
module uart_echo_core #(
  parameter int DataBits     = 8,
  parameter int DivisorTicks = 326,
  parameter int AddrBits     = 3,
  parameter int StopTicks    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  input  logic                auto_i,
  input  logic                send_i,
  output logic                tx_o,
  output logic [DataBits-1:0] dout_o,
  output logic [AddrBits:0]   count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                busy_o,
  output logic                ferr_o,
  output logic                ovf_o
);
  localparam int Depth = 2 ** AddrBits;
  localparam int CW    = AddrBits + 1;
  localparam int DivW  = $clog2(DivisorTicks);
  localparam int TW    = $clog2(StopTicks > 16 ? StopTicks : 16);
  localparam int BW    = $clog2(DataBits);
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif
  logic [DivW-1:0] div_q, div_d;
  logic tick;
  logic s1_q, s2_q;
  state_e rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [TW-1:0] rx_tick_q, rx_tick_d, tx_tick_q, tx_tick_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [DataBits-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic rx_done, rx_ok, push_req, push, pop, launch;
  logic [DataBits-1:0] mem_q [Depth];
  logic [AddrBits-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
`ifdef UART_PARITY_EN
  logic rx_par_q, rx_par_d, tx_par_q, tx_par_d;
`endif
  assign tick = div_q == DivW'(DivisorTicks - 1);
  assign div_d = tick ? '0 : div_q + DivW'(1);
  // free-running oversample tick divider and two-stage rx synchroniser
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      s1_q  <= rx_i;
      s2_q  <= s1_q;
    end
  end
  // RX frame decoder: mid-bit sampling on the synchronised line
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    case (rx_state_q)
      S_IDLE: if (!s2_q) begin
        rx_state_d = S_START;
        rx_tick_d  = '0;
      end
      S_START: if (tick) begin
        if (rx_tick_q == TW'(7)) begin
          rx_state_d = s2_q ? S_IDLE : S_DATA;
          rx_tick_d  = '0;
          rx_bit_d   = '0;
        end else rx_tick_d = rx_tick_q + TW'(1);
      end
      S_DATA: if (tick) begin
        if (rx_tick_q == TW'(15)) begin
          rx_tick_d = '0;
          rx_sh_d   = {s2_q, rx_sh_q[DataBits-1:1]};
          rx_bit_d  = rx_bit_q + BW'(1);
`ifdef UART_PARITY_EN
          if (rx_bit_q == BW'(DataBits - 1)) rx_state_d = S_PARITY;
`else
          if (rx_bit_q == BW'(DataBits - 1)) rx_state_d = S_STOP;
`endif
        end else rx_tick_d = rx_tick_q + TW'(1);
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (tick) begin
        if (rx_tick_q == TW'(15)) begin
          rx_tick_d  = '0;
          rx_par_d   = s2_q;
          rx_state_d = S_STOP;
        end else rx_tick_d = rx_tick_q + TW'(1);
      end
`endif
      S_STOP: if (tick) begin
        if (rx_tick_q == TW'(StopTicks - 1)) begin
          rx_state_d = S_IDLE;
          rx_done    = 1'b1;
        end else rx_tick_d = rx_tick_q + TW'(1);
      end
      default: rx_state_d = S_IDLE;
    endcase
  end
  // RX state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= S_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
`endif
    end
  end
`ifdef UART_PARITY_EN
  assign rx_ok = s2_q & (rx_par_q == ^rx_sh_q);
`else
  assign rx_ok = s2_q;
`endif
  assign push_req = rx_done & rx_ok;
  assign ferr_o   = rx_done & ~rx_ok;
  assign full_o   = cnt_q == CW'(Depth);
  assign empty_o  = cnt_q == '0;
  assign count_o  = cnt_q;
  assign dout_o   = empty_o ? '0 : mem_q[rp_q];
  assign pop      = launch;
  assign push     = push_req & (~full_o | pop);
  assign ovf_o    = push_req & full_o & ~pop;
  // FIFO storage needs no reset: the head is masked while empty
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q] <= rx_sh_q;
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AddrBits'(push);
      rp_q  <= rp_q + AddrBits'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  assign launch = (tx_state_q == S_IDLE) & ~empty_o & (auto_i | send_i);
  // TX frame generator: head is popped into the shifter on launch
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      S_IDLE: if (launch) begin
        tx_state_d = S_START;
        tx_tick_d  = '0;
        tx_bit_d   = '0;
        tx_sh_d    = dout_o;
`ifdef UART_PARITY_EN
        tx_par_d   = ^dout_o;
`endif
      end
      S_START: if (tick) begin
        if (tx_tick_q == TW'(15)) begin
          tx_state_d = S_DATA;
          tx_tick_d  = '0;
        end else tx_tick_d = tx_tick_q + TW'(1);
      end
      S_DATA: if (tick) begin
        if (tx_tick_q == TW'(15)) begin
          tx_tick_d = '0;
          tx_sh_d   = {1'b0, tx_sh_q[DataBits-1:1]};
          tx_bit_d  = tx_bit_q + BW'(1);
`ifdef UART_PARITY_EN
          if (tx_bit_q == BW'(DataBits - 1)) tx_state_d = S_PARITY;
`else
          if (tx_bit_q == BW'(DataBits - 1)) tx_state_d = S_STOP;
`endif
        end else tx_tick_d = tx_tick_q + TW'(1);
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (tick) begin
        if (tx_tick_q == TW'(15)) begin
          tx_state_d = S_STOP;
          tx_tick_d  = '0;
        end else tx_tick_d = tx_tick_q + TW'(1);
      end
`endif
      S_STOP: if (tick) begin
        if (tx_tick_q == TW'(StopTicks - 1)) tx_state_d = S_IDLE;
        else tx_tick_d = tx_tick_q + TW'(1);
      end
      default: tx_state_d = S_IDLE;
    endcase
  end
  // TX state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end
  assign busy_o = tx_state_q != S_IDLE;
`ifdef UART_PARITY_EN
  assign tx_o = tx_state_q == S_START ? 1'b0 : tx_state_q == S_DATA ? tx_sh_q[0] :
                tx_state_q == S_PARITY ? tx_par_q : 1'b1;
`else
  assign tx_o = tx_state_q == S_START ? 1'b0 : tx_state_q == S_DATA ? tx_sh_q[0] : 1'b1;
`endif
endmodule

// File: tb/tb_uart_echo_core.sv
// tb_uart_echo_core: directed echo, manual, overflow, framing and reset checks
module tb_uart_echo_core;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic rx_i = 1'b1;
  logic auto_i = 1'b0;
  logic send_i = 1'b0;
  logic tx_o, empty_o, full_o, busy_o, ferr_o, ovf_o;
  logic [7:0] dout_o;
  logic [2:0] count_o;
  int n_cmp = 0;
  int n_err = 0;
  uart_echo_core #(.DataBits(8), .DivisorTicks(4), .AddrBits(2), .StopTicks(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .auto_i(auto_i), .send_i(send_i),
    .tx_o(tx_o), .dout_o(dout_o), .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .busy_o(busy_o), .ferr_o(ferr_o), .ovf_o(ovf_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    @(negedge clk_i) rx_i = 1'b0;
    repeat (64) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (64) @(negedge clk_i);
    end
    rx_i = stop_ok;
    repeat (stop_ok ? 64 : 48) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (64) @(negedge clk_i);
  endtask
  task automatic grab(output logic [7:0] d, output logic ok);
    int n = 0;
    d = '0;
    ok = 1'b0;
    while (tx_o === 1'b1 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) begin
      check("tx_start_timeout", 1, 0);
      return;
    end
    repeat (32) @(negedge clk_i);
    ok = (tx_o === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (64) @(negedge clk_i);
      d[i] = tx_o;
    end
    repeat (64) @(negedge clk_i);
    ok = ok & (tx_o === 1'b1);
  endtask
  task automatic pulse_send;
    @(negedge clk_i) send_i = 1'b1;
    @(negedge clk_i) send_i = 1'b0;
  endtask
  task automatic wait_idle;
    int n = 0;
    while (busy_o !== 1'b0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) check("busy_timeout", 1, 0);
    @(negedge clk_i);
  endtask
  logic [7:0] d;
  logic ok;
  int n_ovf, n_ferr;
  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_tx", tx_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_count", count_o, 0);
    check("rst_dout", dout_o, 0);
    check("rst_ferr", ferr_o, 0);
    check("rst_ovf", ovf_o, 0);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    auto_i = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      grab(d, ok);
    join
    check("auto_data", d, 8'hA5);
    check("auto_frame", ok, 1);
    wait_idle;
    check("auto_count", count_o, 0);
    check("auto_empty", empty_o, 1);
    auto_i = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("man_count2", count_o, 2);
    check("man_idle_tx", tx_o, 1);
    check("man_idle_busy", busy_o, 0);
    check("man_head", dout_o, 8'h11);
    fork
      begin
        pulse_send;
        repeat (300) @(negedge clk_i);
        pulse_send;
      end
      grab(d, ok);
    join
    check("man_data1", d, 8'h11);
    check("man_frame1", ok, 1);
    wait_idle;
    check("man_count1", count_o, 1);
    check("man_tx_idle2", tx_o, 1);
    fork
      pulse_send;
      grab(d, ok);
    join
    check("man_data2", d, 8'h22);
    wait_idle;
    check("man_count0", count_o, 0);
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    check("ovf_full", full_o, 1);
    check("ovf_count4", count_o, 4);
    n_ovf = 0;
    fork
      send_frame(8'h05, 1'b1);
      repeat (704) @(negedge clk_i) if (ovf_o) n_ovf++;
    join
    check("ovf_pulses", n_ovf, 1);
    check("ovf_count_kept", count_o, 4);
    check("ovf_head", dout_o, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      fork
        pulse_send;
        grab(d, ok);
      join
      check("drain_data", d, i);
      wait_idle;
    end
    check("drain_empty", empty_o, 1);
    n_ferr = 0;
    fork
      send_frame(8'h3C, 1'b0);
      repeat (704) @(negedge clk_i) if (ferr_o) n_ferr++;
    join
    check("ferr_pulses", n_ferr, 1);
    check("ferr_count", count_o, 0);
    n_ferr = 0;
    @(negedge clk_i) rx_i = 1'b0;
    repeat (20) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (300) @(negedge clk_i) if (ferr_o) n_ferr++;
    check("glitch_count", count_o, 0);
    check("glitch_ferr", n_ferr, 0);
    send_frame(8'h5A, 1'b1);
    send_frame(8'h6B, 1'b1);
    check("rmid_count2", count_o, 2);
    pulse_send;
    repeat (200) @(negedge clk_i);
    check("rmid_busy_pre", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    check("rmid_tx", tx_o, 1);
    check("rmid_busy", busy_o, 0);
    check("rmid_empty", empty_o, 1);
    check("rmid_count", count_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    auto_i = 1'b1;
    fork
      send_frame(8'hC3, 1'b1);
      grab(d, ok);
    join
    check("post_rst_data", d, 8'hC3);
    wait_idle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
